// File: rtl/tnkiii_back1_vram_bridge.sv
`default_nettype none
// ============================================================================
// Module  : tnkiii_back1_vram_bridge
// Brief   : CPU-to-Back1 VRAM/scroll-register bus initiator. Optional VRAM
//           readback enabled by defining TNKIII_BACK1_READBACK_EN.
// Revision: 1.0 - initial release
// ============================================================================
module tnkiii_back1_vram_bridge #(
    parameter logic [15:0] VRAM_BASE  = 16'hD800,
    parameter logic [15:0] SCRY_ADDR  = 16'hC900,
    parameter logic [15:0] SCRX_ADDR  = 16'hCA00,
    parameter logic [15:0] MSB_ADDR   = 16'hC800,
    parameter int          STROBE_CYC = 2
) (
    input  logic        clk,
    input  logic        RESET,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_din,
    output logic [7:0]  cpu_dout,
    output logic        cpu_ack,
    output logic        WAITn,
    input  logic        VFLGn,
    input  logic [7:0]  VD_in,
    output logic [7:0]  VD_out,
    output logic [12:0] VA,
    output logic        BACK1_VRAM_CSn,
    output logic        V_C,
    output logic        VRD,
    output logic        VDG,
    output logic        VOE,
    output logic        VWE,
    output logic        B1SX,
    output logic        B1SY,
    output logic        B1X8,
    output logic        B1Y8,
    output logic        B1_COLBK
);

`ifdef TNKIII_BACK1_READBACK_EN
    localparam logic READBACK = 1'b1;
`else
    localparam logic READBACK = 1'b0;
`endif

    localparam logic [2:0] STROBE_LAST = 3'(STROBE_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SLOT, S_SETUP, S_STROBE, S_HOLD, S_REG_SETUP, S_REG_PULSE, S_DONE
    } state_t;

    state_t      r_state, w_next;
    logic [2:0]  r_cnt, w_cnt_next;
    logic        r_req_prev;
    logic        r_we, r_scrx, r_scry, r_msb, r_mapped;
    logic [12:0] r_va;
    logic [7:0]  r_din;

    logic [16:0] w_addr_ext;
    logic        w_in_vram, w_is_scrx, w_is_scry, w_is_msb, w_is_reg, w_start;
    logic [12:0] w_va;
    logic        w_cur_we, w_cur_scrx, w_cur_scry, w_cur_msb, w_cur_mapped;
    logic [12:0] w_cur_va;
    logic [7:0]  w_cur_din;
    logic        w_bus;

    assign w_addr_ext = {1'b0, cpu_addr};
    assign w_in_vram  = (w_addr_ext >= {1'b0, VRAM_BASE}) &&
                        (w_addr_ext <  ({1'b0, VRAM_BASE} + 17'd8192));
    assign w_va       = cpu_addr[12:0] - VRAM_BASE[12:0];
    assign w_is_scrx  = (cpu_addr == SCRX_ADDR);
    assign w_is_scry  = (cpu_addr == SCRY_ADDR);
    assign w_is_msb   = (cpu_addr == MSB_ADDR);
    assign w_is_reg   = w_is_scrx | w_is_scry | w_is_msb;
    assign w_start    = (r_state == S_IDLE) && cpu_req && !r_req_prev;

    // Outputs are registered from the next state, so in IDLE the live request
    // must be used; afterwards the copy latched at the request edge.
    always_comb begin
        w_cur_we     = r_we;
        w_cur_va     = r_va;
        w_cur_din    = r_din;
        w_cur_scrx   = r_scrx;
        w_cur_scry   = r_scry;
        w_cur_msb    = r_msb;
        w_cur_mapped = r_mapped;
        if (r_state == S_IDLE) begin
            w_cur_we     = cpu_we;
            w_cur_va     = w_va;
            w_cur_din    = cpu_din;
            w_cur_scrx   = w_is_scrx;
            w_cur_scry   = w_is_scry;
            w_cur_msb    = w_is_msb;
            w_cur_mapped = w_in_vram | w_is_reg;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    if (w_in_vram && (cpu_we || READBACK)) w_next = S_SLOT;
                    else if (w_is_reg && cpu_we)           w_next = S_REG_SETUP;
                    else                                   w_next = S_DONE;
                end
            end
            S_SLOT:      if (VFLGn) w_next = S_SETUP;
            S_SETUP: begin
                if (VFLGn) begin
                    w_next     = S_STROBE;
                    w_cnt_next = 3'd0;
                end else begin
                    w_next = S_SLOT;
                end
            end
            S_STROBE: begin
                if (r_cnt == STROBE_LAST) w_next = S_HOLD;
                else                      w_cnt_next = r_cnt + 3'd1;
            end
            S_HOLD:      w_next = S_DONE;
            S_REG_SETUP: w_next = S_REG_PULSE;
            S_REG_PULSE: w_next = S_DONE;
            S_DONE:      w_next = S_IDLE;
            default:     w_next = S_IDLE;
        endcase
    end

    assign w_bus = (w_next == S_SETUP) || (w_next == S_STROBE) || (w_next == S_HOLD);

    always_ff @(posedge clk) begin
        if (RESET) begin
            r_state        <= S_IDLE;
            r_cnt          <= 3'd0;
            r_req_prev     <= cpu_req;   // a level held through reset is not a new edge
            r_we           <= 1'b0;
            r_va           <= 13'd0;
            r_din          <= 8'd0;
            r_scrx         <= 1'b0;
            r_scry         <= 1'b0;
            r_msb          <= 1'b0;
            r_mapped       <= 1'b0;
            cpu_dout       <= 8'hFF;
            cpu_ack        <= 1'b0;
            WAITn          <= 1'b1;
            VD_out         <= 8'hFF;
            VA             <= 13'd0;
            BACK1_VRAM_CSn <= 1'b1;
            V_C            <= 1'b0;
            VRD            <= 1'b0;
            VDG            <= 1'b1;
            VOE            <= 1'b1;
            VWE            <= 1'b1;
            B1SX           <= 1'b0;
            B1SY           <= 1'b0;
            B1X8           <= 1'b0;
            B1Y8           <= 1'b0;
            B1_COLBK       <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_cnt      <= w_cnt_next;
            r_req_prev <= cpu_req;
            if (w_start) begin
                r_we     <= cpu_we;
                r_va     <= w_va;
                r_din    <= cpu_din;
                r_scrx   <= w_is_scrx;
                r_scry   <= w_is_scry;
                r_msb    <= w_is_msb;
                r_mapped <= w_in_vram | w_is_reg;
            end

            cpu_ack        <= (w_next == S_DONE);
            WAITn          <= !((w_next != S_IDLE) && w_cur_mapped);
            V_C            <= w_bus;
            BACK1_VRAM_CSn <= !w_bus;
            VDG            <= !w_bus;
            VRD            <= w_bus && w_cur_we;
            VA             <= w_bus ? w_cur_va : 13'd0;
            VWE            <= !((w_next == S_STROBE) && w_cur_we);
            VOE            <= !((w_next == S_STROBE) && !w_cur_we);
            VD_out         <= ((w_bus && w_cur_we) || (w_next == S_REG_SETUP) ||
                               (w_next == S_REG_PULSE)) ? w_cur_din : 8'hFF;
            B1SX           <= (w_next == S_REG_PULSE) && w_cur_scrx;
            B1SY           <= (w_next == S_REG_PULSE) && w_cur_scry;
            if ((w_next == S_REG_PULSE) && w_cur_msb) begin
                B1Y8     <= w_cur_din[0];
                B1X8     <= w_cur_din[1];
                B1_COLBK <= w_cur_din[6];
            end

            // Reads that bypass the VRAM strobe return all-ones.
            if ((r_state == S_STROBE) && (w_next == S_HOLD) && !r_we)
                cpu_dout <= VD_in;
            else if ((w_next == S_DONE) && (r_state != S_HOLD) && !w_cur_we)
                cpu_dout <= 8'hFF;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_tnkiii_back1_vram_bridge.sv
`default_nettype none
// ============================================================================
// Module  : tb_tnkiii_back1_vram_bridge
// Brief   : Directed self-checking bench for tnkiii_back1_vram_bridge.
// Revision: 1.0 - initial release
// ============================================================================
module tb_tnkiii_back1_vram_bridge;

    logic        clk = 1'b0;
    logic        RESET, cpu_req, cpu_we, VFLGn;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_din, VD_in;
    logic [7:0]  cpu_dout, VD_out;
    logic        cpu_ack, WAITn;
    logic [12:0] VA;
    logic        BACK1_VRAM_CSn, V_C, VRD, VDG, VOE, VWE;
    logic        B1SX, B1SY, B1X8, B1Y8, B1_COLBK;

    tnkiii_back1_vram_bridge dut (
        .clk(clk), .RESET(RESET), .cpu_req(cpu_req), .cpu_we(cpu_we),
        .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_dout(cpu_dout),
        .cpu_ack(cpu_ack), .WAITn(WAITn), .VFLGn(VFLGn), .VD_in(VD_in),
        .VD_out(VD_out), .VA(VA), .BACK1_VRAM_CSn(BACK1_VRAM_CSn), .V_C(V_C),
        .VRD(VRD), .VDG(VDG), .VOE(VOE), .VWE(VWE), .B1SX(B1SX), .B1SY(B1SY),
        .B1X8(B1X8), .B1Y8(B1Y8), .B1_COLBK(B1_COLBK)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Per-cycle samples of one transaction; index k = cycle k after the request edge.
    logic        s_vwe [0:31];
    logic        s_voe [0:31];
    logic        s_vc  [0:31];
    logic        s_csn [0:31];
    logic        s_vrd [0:31];
    logic        s_wn  [0:31];
    logic        s_sx  [0:31];
    logic [12:0] s_va  [0:31];
    logic [7:0]  s_vd  [0:31];
    int          ack_cyc, n_ack, n_vwe, n_voe, n_vc, n_wait, n_sx, n_sy;
    logic [7:0]  dout_at_ack;

    // vlow bit k drives VFLGn low during cycle k.
    task automatic do_req(input logic we, input logic [15:0] a, input logic [7:0] d,
                          input logic [31:0] vlow, input logic hold);
        @(negedge clk);
        cpu_we = we; cpu_addr = a; cpu_din = d; cpu_req = 1'b1; VFLGn = ~vlow[0];
        ack_cyc = -1; n_ack = 0; n_vwe = 0; n_voe = 0; n_vc = 0; n_wait = 0; n_sx = 0; n_sy = 0;
        dout_at_ack = 8'h00;
        for (int k = 1; k < 24; k++) begin
            @(posedge clk); #1;
            s_vwe[k] = VWE; s_voe[k] = VOE; s_vc[k] = V_C; s_csn[k] = BACK1_VRAM_CSn;
            s_vrd[k] = VRD; s_wn[k] = WAITn; s_sx[k] = B1SX; s_va[k] = VA; s_vd[k] = VD_out;
            if (cpu_ack) begin
                n_ack++;
                if (ack_cyc < 0) begin
                    ack_cyc = k;
                    dout_at_ack = cpu_dout;
                end
            end
            if (!VWE)   n_vwe++;
            if (!VOE)   n_voe++;
            if (V_C)    n_vc++;
            if (!WAITn) n_wait++;
            if (B1SX)   n_sx++;
            if (B1SY)   n_sy++;
            VFLGn = ~vlow[k];
            if (ack_cyc >= 0 && !hold) cpu_req = 1'b0;
        end
        cpu_req = 1'b0;
        VFLGn   = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        RESET = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0000;
        cpu_din = 8'h00; VD_in = 8'hC3; VFLGn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_ctl", {V_C, BACK1_VRAM_CSn, VRD, VDG, VOE, VWE, B1SX, B1SY,
                               B1X8, B1Y8, B1_COLBK, cpu_ack, WAITn}, 13'b0101110000001);
        check_eq("reset_va", VA, 13'h0000);
        check_eq("reset_vd", VD_out, 8'hFF);
        check_eq("reset_dout", cpu_dout, 8'hFF);
        @(negedge clk); RESET = 1'b0;
        repeat (2) @(posedge clk);

        // VRAM write, free slots
        do_req(1'b1, 16'hD801, 8'h5A, 32'h0, 1'b0);
        check_eq("wr_ack_cyc", ack_cyc, 6);
        check_eq("wr_vwe_cyc", {s_vwe[2], s_vwe[3], s_vwe[4], s_vwe[5]}, 4'b1001);
        check_eq("wr_vwe_cnt", n_vwe, 2);
        check_eq("wr_voe_cnt", n_voe, 0);
        check_eq("wr_va", {s_va[2], s_va[3], s_va[5]}, {13'h0001, 13'h0001, 13'h0001});
        check_eq("wr_vd", {s_vd[2], s_vd[3], s_vd[5]}, 24'h5A5A5A);
        check_eq("wr_ctl", {s_vrd[3], s_vc[3], s_csn[3], s_vc[1]}, 4'b1100);
        check_eq("wr_waitn", {s_wn[1], s_wn[6], s_wn[7]}, 3'b001);

        // VRAM read at top of window
        VD_in = 8'hC3;
        do_req(1'b0, 16'hF7FF, 8'h00, 32'h0, 1'b0);
`ifdef TNKIII_BACK1_READBACK_EN
        check_eq("rd_ack_cyc", ack_cyc, 6);
        check_eq("rd_voe", {s_voe[2], s_voe[3], s_voe[4], s_voe[5]}, 4'b1001);
        check_eq("rd_va", s_va[3], 13'h1FFF);
        check_eq("rd_vrd", s_vrd[3], 1'b0);
        check_eq("rd_dout", dout_at_ack, 8'hC3);
`else
        check_eq("rd_ack_cyc", ack_cyc, 1);
        check_eq("rd_voe_cnt", n_voe, 0);
        check_eq("rd_vc_cnt", n_vc, 0);
        check_eq("rd_dout", dout_at_ack, 8'hFF);
`endif

        // Busy video slots in cycles 0..4
        do_req(1'b1, 16'hD900, 8'h11, 32'h0000_001F, 1'b0);
        check_eq("slot_setup", {s_vc[5], s_vc[6]}, 2'b01);
        check_eq("slot_vwe", {s_vwe[6], s_vwe[7], s_vwe[8], s_vwe[9]}, 4'b1001);
        check_eq("slot_ack_cyc", ack_cyc, 10);

        // VFLGn falls during SETUP: retry without strobe
        do_req(1'b1, 16'hD802, 8'h22, 32'h0000_0004, 1'b0);
        check_eq("retry_slot", {s_vc[2], s_vc[3], s_vwe[3], s_vc[4]}, 4'b1011);
        check_eq("retry_vwe_cnt", n_vwe, 2);
        check_eq("retry_ack_cyc", ack_cyc, 8);

        // Register writes
        do_req(1'b1, 16'hC800, 8'h43, 32'h0, 1'b0);
        check_eq("msb_ack_cyc", ack_cyc, 3);
        check_eq("msb_bits", {B1Y8, B1X8, B1_COLBK}, 3'b111);
        check_eq("msb_no_pulse", n_sx + n_sy, 0);
        do_req(1'b1, 16'hCA00, 8'h80, 32'h0, 1'b0);
        check_eq("scrx_pulse", {s_sx[1], s_sx[2], s_sx[3]}, 3'b010);
        check_eq("scrx_pulse_cnt", n_sx, 1);
        check_eq("scrx_vd", {s_vd[1], s_vd[2]}, 16'h8080);
        check_eq("scrx_ack_cyc", ack_cyc, 3);
        check_eq("scrx_msb_kept", {B1Y8, B1X8, B1_COLBK}, 3'b111);
        do_req(1'b1, 16'hC900, 8'h07, 32'h0, 1'b0);
        check_eq("scry_pulse", {n_sy, n_sx}, {32'd1, 32'd0});
        do_req(1'b0, 16'hCA00, 8'h00, 32'h0, 1'b0);
        check_eq("reg_rd", {ack_cyc[7:0], dout_at_ack, 8'(n_sx)}, 24'h01FF00);

        // Unmapped address, request held high after ack
        do_req(1'b1, 16'h0000, 8'h99, 32'h0, 1'b1);
        check_eq("unmap_ack_cyc", ack_cyc, 1);
        check_eq("unmap_ack_cnt", n_ack, 1);
        check_eq("unmap_waitn", n_wait, 0);
        check_eq("unmap_bus", n_vc + n_vwe + n_voe, 0);

        // Reset during STROBE
        @(negedge clk);
        cpu_we = 1'b1; cpu_addr = 16'hD800; cpu_din = 8'hA5; cpu_req = 1'b1; VFLGn = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_in_strobe", VWE, 1'b0);
        RESET = 1'b1;
        @(posedge clk); #1;
        check_eq("rst_ctl", {V_C, BACK1_VRAM_CSn, VRD, VDG, VOE, VWE, cpu_ack, WAITn}, 8'b01011101);
        check_eq("rst_va_vd", {VA, VD_out}, {13'h0000, 8'hFF});
        RESET = 1'b0;
        n_ack = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (cpu_ack) n_ack++;
        end
        check_eq("rst_no_ack", n_ack, 0);
        cpu_req = 1'b0;
        repeat (2) @(posedge clk);
        do_req(1'b1, 16'hD800, 8'hA5, 32'h0, 1'b0);
        check_eq("post_rst_ack_cyc", ack_cyc, 6);
        check_eq("post_rst_vd", s_vd[3], 8'hA5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
